awb_gain: RTL

Gray-world auto white balance stage directly downstream of dead pixel correction in the ISP pixel chain. It consumes the corrected 24-bit {R,G,B} stream and applies per-channel Q4.8 gains through a 2-cycle pipeline. It also accumulates per-channel frame sums and computes the next frame's R/B gains with a sequential divider during blanking. New gains take effect at the next start of frame, so a frame never switches gains mid-way.

---
 rtl/awb_gain.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/awb_gain.sv
// awb_gain: gray-world auto white balance stage.
//
// Applies per-channel Q4.8 gains to a 24-bit {R,G,B} pixel stream through a
// 2-stage pipeline. G gain is fixed at unity. Active gains are reloaded from
// the pending gains on every sof pixel, so a frame never changes gains
// part-way through.
//
// Build option ISP_AWB_AUTO_EN:
//   defined   - per-frame channel sums plus a sequential restoring divider
//               produce the pending gains (sum_g<<8)/sum_r and
//               (sum_g<<8)/sum_b during blanking. cfg_gain_* are ignored.
//   undefined - the pending gains are cfg_gain_r/cfg_gain_b. There are no
//               statistics and stat_done is tied low.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   awb_en               0 = bypass with unity gains and no statistics
//   sof                  start of frame, coincident with the first pix_vld
//   pix_vld              input pixel valid
//   pixel_data_in        {R[23:16],G[15:8],B[7:0]}
//   cfg_gain_r/_b        manual gains, Q4.8
//   pix_vld_out          pix_vld delayed by 2 cycles
//   pixel_data_out       gained pixel, 2 cycles after input
//   gain_r/gain_b        active gains
//   stat_done            one-cycle pulse when new pending gains are written

// One colour channel: stage 1 multiplies, stage 2 rounds half up and
// saturates to 8 bits.
module awb_lane (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  pix,
  input  logic [11:0] gain,
  output logic [7:0]  pix_out
);
  logic [19:0] prod;
  logic [20:0] rnd;
  logic [7:0]  unused_lsb;

  assign rnd        = {1'b0, prod} + 21'd128;
  assign unused_lsb = rnd[7:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod    <= '0;
      pix_out <= '0;
    end else begin
      prod    <= {12'd0, pix} * {8'd0, gain};
      pix_out <= (|rnd[20:16]) ? 8'hff : rnd[15:8];
    end
  end
endmodule

module awb_gain #(
  parameter int          H        = 720,
  parameter int          V        = 480,
  parameter int          SUM_W    = 28,
  parameter logic [11:0] GAIN_MAX = 12'h400
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        awb_en,
  input  logic        sof,
  input  logic        pix_vld,
  input  logic [23:0] pixel_data_in,
  input  logic [11:0] cfg_gain_r,
  input  logic [11:0] cfg_gain_b,
  output logic        pix_vld_out,
  output logic [23:0] pixel_data_out,
  output logic [11:0] gain_r,
  output logic [11:0] gain_b,
  output logic        stat_done
);
  localparam int          NUM_LANES = 3;
  localparam int          STAGES    = 2;
  localparam logic [11:0] UNITY     = 12'h100;

  logic [11:0] pend_r, pend_b;
  logic [11:0] act_r, act_b;
  logic [11:0] g_r, g_b;
  logic        load;

  // ---------------------------------------------------------------------------
  // Apply path
  // ---------------------------------------------------------------------------
  // The sof pixel itself already sees the freshly loaded gains, so the
  // pending values are forwarded around the active registers on that cycle.
  assign load = sof & pix_vld;
  assign g_r  = awb_en ? (load ? pend_r : act_r) : UNITY;
  assign g_b  = awb_en ? (load ? pend_b : act_b) : UNITY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_r <= UNITY;
      act_b <= UNITY;
    end else if (load) begin
      act_r <= pend_r;
      act_b <= pend_b;
    end
  end

  assign gain_r = act_r;
  assign gain_b = act_b;

  logic [NUM_LANES-1:0][7:0]  pin, pout;
  logic [NUM_LANES-1:0][11:0] lane_gain;

  assign pin       = pixel_data_in;
  assign lane_gain = {g_r, UNITY, g_b};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    awb_lane u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .pix     (pin[i]),
      .gain    (lane_gain[i]),
      .pix_out (pout[i])
    );
  end

  assign pixel_data_out = pout;

  logic [STAGES:1] vld_pipe;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], pix_vld};
  end
  assign pix_vld_out = vld_pipe[STAGES];

`ifdef ISP_AWB_AUTO_EN
  // ---------------------------------------------------------------------------
  // Frame statistics and gain computation
  // ---------------------------------------------------------------------------
  localparam int TOTAL = H * V;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int DW    = SUM_W + 8;
  localparam int BW    = $clog2(DW);

  typedef enum logic [2:0] {IDLE, ACCUM, DIV_R, DIV_B, UPDATE} state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt, cnt_base;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [SUM_W-1:0] add_r, add_g, add_b;
  logic [SUM_W-1:0] rem, dsr, rem_n;
  logic [SUM_W:0]   rem_s, trial;
  logic [DW-1:0]    quo, quo_n;
  logic [BW-1:0]    bcnt;
  logic [11:0]      qr, qb, pend_r_q, pend_b_q;
  logic             first, accum_go, at_last, ge, div_end;
  logic             unused_cfg;

  assign unused_cfg = ^{cfg_gain_r, cfg_gain_b};

  // A sof pixel restarts accumulation from any state; the sums then start
  // from this pixel alone.
  assign first    = sof & pix_vld & awb_en;
  assign accum_go = first | ((st == ACCUM) & pix_vld);
  assign cnt_base = first ? '0 : cnt;
  assign at_last  = (cnt_base == CNT_W'(TOTAL - 1));
  assign add_r    = (first ? '0 : sum_r) + {{(SUM_W-8){1'b0}}, pixel_data_in[23:16]};
  assign add_g    = (first ? '0 : sum_g) + {{(SUM_W-8){1'b0}}, pixel_data_in[15:8]};
  assign add_b    = (first ? '0 : sum_b) + {{(SUM_W-8){1'b0}}, pixel_data_in[7:0]};

  // Restoring divider step: quo starts as the dividend and shifts out its
  // MSB into the partial remainder while quotient bits shift in at the LSB.
  // rem < dsr always holds, so trial's top bit is a clean borrow flag.
  assign rem_s   = {rem, quo[DW-1]};
  assign trial   = rem_s - {1'b0, dsr};
  assign ge      = ~trial[SUM_W];
  assign rem_n   = ge ? trial[SUM_W-1:0] : rem_s[SUM_W-1:0];
  assign quo_n   = {quo[DW-2:0], ge};
  assign div_end = (bcnt == BW'(DW - 1));

  // A zero divisor leaves a meaningless quotient; force the ceiling instead.
  function automatic logic [11:0] clamp(input logic [DW-1:0] q, input logic zero);
    if (zero || (q > DW'(GAIN_MAX))) return GAIN_MAX;
    return q[11:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      cnt       <= '0;
      sum_r     <= '0;
      sum_g     <= '0;
      sum_b     <= '0;
      rem       <= '0;
      dsr       <= '0;
      quo       <= '0;
      bcnt      <= '0;
      qr        <= UNITY;
      qb        <= UNITY;
      pend_r_q  <= UNITY;
      pend_b_q  <= UNITY;
      stat_done <= 1'b0;
    end else begin
      stat_done <= 1'b0;
      if (!awb_en) begin
        st <= IDLE;
      end else if (accum_go) begin
        sum_r <= add_r;
        sum_g <= add_g;
        sum_b <= add_b;
        if (at_last) begin
          st   <= DIV_R;
          rem  <= '0;
          quo  <= {add_g, 8'd0};
          dsr  <= add_r;
          bcnt <= '0;
        end else begin
          st  <= ACCUM;
          cnt <= cnt_base + 1'b1;
        end
      end else begin
        case (st)
          DIV_R: begin
            rem  <= rem_n;
            quo  <= quo_n;
            bcnt <= bcnt + 1'b1;
            if (div_end) begin
              qr   <= clamp(quo_n, dsr == '0);
              rem  <= '0;
              quo  <= {sum_g, 8'd0};
              dsr  <= sum_b;
              bcnt <= '0;
              st   <= DIV_B;
            end
          end
          DIV_B: begin
            rem  <= rem_n;
            quo  <= quo_n;
            bcnt <= bcnt + 1'b1;
            if (div_end) begin
              qb <= clamp(quo_n, dsr == '0);
              st <= UPDATE;
            end
          end
          UPDATE: begin
            pend_r_q  <= qr;
            pend_b_q  <= qb;
            stat_done <= 1'b1;
            st        <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign pend_r = pend_r_q;
  assign pend_b = pend_b_q;
`else
  assign pend_r    = cfg_gain_r;
  assign pend_b    = cfg_gain_b;
  assign stat_done = 1'b0;
`endif

endmodule
